// File: rtl/mipi_capture_pkg.sv
// ============================================================================
// Module  : mipi_capture_pkg
// Brief   : Shared state encoding, default geometry and RGB888->RGB565
//           conversion for the MIPI capture sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mipi_capture_pkg;

  // Default frame geometry and bus sizing
  localparam int c_DEF_WIDTH   = 640;
  localparam int c_DEF_HEIGHT  = 480;
  localparam int c_DEF_ADDR_W  = 32;
  localparam int c_DEF_FIFO_AW = 4;

  // Width of the X/Y position counters and crop window fields
  localparam int c_XY_W = 11;

  // Sequencer state encoding
  typedef logic [1:0] captureState_t;
  localparam captureState_t c_ST_IDLE    = 2'd0;
  localparam captureState_t c_ST_ARMED   = 2'd1;
  localparam captureState_t c_ST_CAPTURE = 2'd2;
  localparam captureState_t c_ST_DRAIN   = 2'd3;

  // Truncating RGB888 {R,G,B} to RGB565 conversion
  function automatic logic [15:0] rgb888To565(input logic [23:0] pix);
    return {pix[23:19], pix[15:10], pix[7:3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mipi_capture_fifo.sv
// ============================================================================
// Module  : mipi_capture_fifo
// Brief   : Synchronous show-ahead FIFO. Writes while full and reads while
//           empty are ignored; the head word is visible on oRdData whenever
//           oEmpty is low. Reset flushes the contents.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mipi_capture_fifo #(
  parameter int pDATA_W = 48,
  parameter int pAW     = 4
) (
  input  logic               iCLK,
  input  logic               iRESETn,
  input  logic               iWrEn,
  input  logic [pDATA_W-1:0] iWrData,
  input  logic               iRdEn,
  output logic [pDATA_W-1:0] oRdData,
  output logic               oFull,
  output logic               oEmpty
);

  localparam int c_DEPTH = 1 << pAW;
  localparam logic [pAW:0] c_FULL_CNT = (pAW+1)'(c_DEPTH);

  logic [pDATA_W-1:0] r_mem [c_DEPTH];
  logic [pAW-1:0]     r_wrPtr;
  logic [pAW-1:0]     r_rdPtr;
  logic [pAW:0]       r_count;
  logic               w_wr;
  logic               w_rd;

  assign w_wr   = iWrEn && !oFull;
  assign w_rd   = iRdEn && !oEmpty;
  assign oFull  = (r_count == c_FULL_CNT);
  assign oEmpty = (r_count == '0);
  assign oRdData = r_mem[r_rdPtr];

  // Storage array; no reset needed since pointers define validity
  always_ff @(posedge iCLK) begin
    if (w_wr) r_mem[r_wrPtr] <= iWrData;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rd) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mipi_capture_ctrl.sv
// ============================================================================
// Module  : mipi_capture_ctrl
// Brief   : Capture sequencer from the MIPI RGB888 pixel stream to an
//           Avalon-MM frame-buffer write port. Arms on iSTART, aligns to the
//           receiver frame-start strobe, tracks X/Y, converts to RGB565,
//           buffers through a FIFO and writes linear byte addresses.
//           Optional crop window enabled by defining MIPI_CAPTURE_CROP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mipi_capture_ctrl
  import mipi_capture_pkg::*;
#(
  parameter int pWIDTH   = c_DEF_WIDTH,
  parameter int pHEIGHT  = c_DEF_HEIGHT,
  parameter int pADDR_W  = c_DEF_ADDR_W,
  parameter int pFIFO_AW = c_DEF_FIFO_AW
) (
  input  logic               iCLK,
  input  logic               iRESETn,
  input  logic [23:0]        iMIPI_DATA,
  input  logic               iMIPI_START,
  input  logic               iMIPI_DATAVALID,
  input  logic [pADDR_W-1:0] iBASE,
  input  logic               iSTART,
  input  logic               iSTOP,
  input  logic               iCONTINUOUS,
  input  logic [10:0]        iCROP_X,
  input  logic [10:0]        iCROP_Y,
  input  logic [10:0]        iCROP_W,
  input  logic [10:0]        iCROP_H,
  output logic [pADDR_W-1:0] oFB_ADDRESS,
  output logic               oFB_WRITE,
  output logic [15:0]        oFB_WRITEDATA,
  input  logic               iFB_WAITREQUEST,
  output logic               oBUSY,
  output logic               oFRAME_DONE,
  output logic               oOVERFLOW,
  output logic [15:0]        oFRAME_COUNT
);

  localparam int c_FIFO_W = 16 + pADDR_W;
  localparam logic [c_XY_W-1:0] c_LAST_X = c_XY_W'(pWIDTH - 1);
  localparam logic [c_XY_W-1:0] c_LAST_Y = c_XY_W'(pHEIGHT - 1);

  captureState_t       r_state;
  captureState_t       w_stateNext;
  logic [pADDR_W-1:0]  r_base;
  logic [pADDR_W-1:0]  r_ptr;
  logic [c_XY_W-1:0]   r_x;
  logic [c_XY_W-1:0]   r_y;
  logic                r_abort;
  logic                r_overflow;
  logic [15:0]         r_frameCount;
  logic                r_fbWrite;
  logic [pADDR_W-1:0]  r_fbAddr;
  logic [15:0]         r_fbData;

  logic                w_startAcc;
  logic                w_frameStart;
  logic                w_pixValid;
  logic                w_lastX;
  logic                w_lastY;
  logic                w_lastPix;
  logic                w_inWin;
  logic                w_push;
  logic                w_pop;
  logic                w_drainIdle;
  logic                w_busy;
  logic                w_frameDone;
  logic                w_fifoFull;
  logic                w_fifoEmpty;
  logic [c_FIFO_W-1:0] w_fifoWrData;
  logic [c_FIFO_W-1:0] w_fifoRdData;

  // Command and stream qualifiers. A pixel coinciding with the frame-start
  // strobe is never counted; iSTOP wins over a same-cycle pixel.
  assign w_startAcc   = (r_state == c_ST_IDLE) && iSTART;
  assign w_frameStart = iMIPI_START &&
                        ((r_state == c_ST_ARMED) || (r_state == c_ST_CAPTURE));
  assign w_pixValid   = (r_state == c_ST_CAPTURE) && iMIPI_DATAVALID &&
                        !iMIPI_START && !iSTOP;
  assign w_lastX      = (r_x == c_LAST_X);
  assign w_lastY      = (r_y == c_LAST_Y);
  assign w_lastPix    = w_pixValid && w_lastX && w_lastY;
  assign w_push       = w_pixValid && w_inWin;
  assign w_pop        = !w_fifoEmpty && (!r_fbWrite || !iFB_WAITREQUEST);
  assign w_drainIdle  = w_fifoEmpty && !r_fbWrite;

`ifdef MIPI_CAPTURE_CROP_EN
  logic [c_XY_W-1:0] r_cropX;
  logic [c_XY_W-1:0] r_cropY;
  logic [c_XY_W-1:0] r_cropW;
  logic [c_XY_W-1:0] r_cropH;
  logic [c_XY_W:0]   w_cropXEnd;
  logic [c_XY_W:0]   w_cropYEnd;

  // Crop window is frozen for the whole armed session
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_cropX <= '0;
      r_cropY <= '0;
      r_cropW <= '0;
      r_cropH <= '0;
    end else if (w_startAcc) begin
      r_cropX <= iCROP_X;
      r_cropY <= iCROP_Y;
      r_cropW <= iCROP_W;
      r_cropH <= iCROP_H;
    end
  end

  // End bounds carry one extra bit so a window reaching the edge never wraps
  assign w_cropXEnd = {1'b0, r_cropX} + {1'b0, r_cropW};
  assign w_cropYEnd = {1'b0, r_cropY} + {1'b0, r_cropH};
  assign w_inWin    = (r_x >= r_cropX) && ({1'b0, r_x} < w_cropXEnd) &&
                      (r_y >= r_cropY) && ({1'b0, r_y} < w_cropYEnd);
`else
  // Without cropping every pixel of the frame is stored
  wire w_unusedCrop = ^{iCROP_X, iCROP_Y, iCROP_W, iCROP_H};
  assign w_inWin = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) r_state <= c_ST_IDLE;
    else          r_state <= w_stateNext;
  end

  // FSM next-state logic
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (iSTART) w_stateNext = c_ST_ARMED;
      end
      c_ST_ARMED: begin
        if (iSTOP)            w_stateNext = c_ST_IDLE;
        else if (iMIPI_START) w_stateNext = c_ST_CAPTURE;
      end
      c_ST_CAPTURE: begin
        if (iSTOP)            w_stateNext = c_ST_DRAIN;
        else if (iMIPI_START) w_stateNext = c_ST_CAPTURE;
        else if (w_lastPix)   w_stateNext = c_ST_DRAIN;
      end
      c_ST_DRAIN: begin
        if (w_drainIdle)
          w_stateNext = (iCONTINUOUS && !r_abort) ? c_ST_ARMED : c_ST_IDLE;
      end
      default: w_stateNext = c_ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and completion pulse in the cycle after the last write
  always_comb begin
    w_busy      = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      c_ST_IDLE:  w_busy = 1'b0;
      c_ST_DRAIN: begin
        w_busy      = 1'b1;
        w_frameDone = w_drainIdle && !r_abort;
      end
      default:    w_busy = 1'b1;
    endcase
  end

  // Session registers: base latch, abort flag, sticky overflow, frame counter
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_base       <= '0;
      r_abort      <= 1'b0;
      r_overflow   <= 1'b0;
      r_frameCount <= '0;
    end else begin
      if (w_startAcc) r_base <= iBASE;

      if (w_startAcc)
        r_abort <= 1'b0;
      else if ((r_state == c_ST_CAPTURE) && iSTOP)
        r_abort <= 1'b1;
      else if ((r_state == c_ST_DRAIN) && w_drainIdle)
        r_abort <= 1'b0;

      if (w_startAcc)
        r_overflow <= 1'b0;
      else if (w_push && w_fifoFull)
        r_overflow <= 1'b1;

      if (w_frameDone) r_frameCount <= r_frameCount + 16'd1;
    end
  end

  // Position and write-pointer tracking; the pointer advances for every
  // in-window pixel so a dropped pixel leaves a hole, not a shift
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_ptr <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_startAcc) begin
      r_ptr <= iBASE;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_frameStart) begin
      r_ptr <= r_base;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_pixValid) begin
      if (w_inWin) r_ptr <= r_ptr + pADDR_W'(2);
      if (w_lastX) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_fifoWrData = {r_ptr, rgb888To565(iMIPI_DATA)};

  mipi_capture_fifo #(
    .pDATA_W (c_FIFO_W),
    .pAW     (pFIFO_AW)
  ) u_fifo (
    .iCLK    (iCLK),
    .iRESETn (iRESETn),
    .iWrEn   (w_push),
    .iWrData (w_fifoWrData),
    .iRdEn   (w_pop),
    .oRdData (w_fifoRdData),
    .oFull   (w_fifoFull),
    .oEmpty  (w_fifoEmpty)
  );

  // Avalon write stage: holds address/data steady under waitrequest and
  // reloads from the FIFO head in the same cycle a transfer completes
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_fbWrite <= 1'b0;
      r_fbAddr  <= '0;
      r_fbData  <= '0;
    end else if (w_pop) begin
      r_fbWrite <= 1'b1;
      r_fbAddr  <= w_fifoRdData[c_FIFO_W-1:16];
      r_fbData  <= w_fifoRdData[15:0];
    end else if (r_fbWrite && !iFB_WAITREQUEST) begin
      r_fbWrite <= 1'b0;
    end
  end

  assign oFB_ADDRESS   = r_fbAddr;
  assign oFB_WRITE     = r_fbWrite;
  assign oFB_WRITEDATA = r_fbData;
  assign oBUSY         = w_busy;
  assign oFRAME_DONE   = w_frameDone;
  assign oOVERFLOW     = r_overflow;
  assign oFRAME_COUNT  = r_frameCount;

endmodule

`default_nettype wire

// File: tb/tb_mipi_capture_ctrl.sv
// ============================================================================
// Module  : tb_mipi_capture_ctrl
// Brief   : Directed self-checking bench for mipi_capture_ctrl on an 8x4
//           frame with a 4-deep FIFO. Crop scenario runs only when
//           MIPI_CAPTURE_CROP_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mipi_capture_ctrl;

  logic        iCLK = 1'b0;
  logic        iRESETn = 1'b0;
  logic [23:0] iMIPI_DATA = '0;
  logic        iMIPI_START = 1'b0;
  logic        iMIPI_DATAVALID = 1'b0;
  logic [31:0] iBASE = '0;
  logic        iSTART = 1'b0;
  logic        iSTOP = 1'b0;
  logic        iCONTINUOUS = 1'b0;
  logic [10:0] iCROP_X = 11'd0;
  logic [10:0] iCROP_Y = 11'd0;
  logic [10:0] iCROP_W = 11'd8;
  logic [10:0] iCROP_H = 11'd4;
  logic [31:0] oFB_ADDRESS;
  logic        oFB_WRITE;
  logic [15:0] oFB_WRITEDATA;
  logic        iFB_WAITREQUEST = 1'b0;
  logic        oBUSY;
  logic        oFRAME_DONE;
  logic        oOVERFLOW;
  logic [15:0] oFRAME_COUNT;

  mipi_capture_ctrl #(
    .pWIDTH   (8),
    .pHEIGHT  (4),
    .pADDR_W  (32),
    .pFIFO_AW (2)
  ) dut (
    .iCLK            (iCLK),
    .iRESETn         (iRESETn),
    .iMIPI_DATA      (iMIPI_DATA),
    .iMIPI_START     (iMIPI_START),
    .iMIPI_DATAVALID (iMIPI_DATAVALID),
    .iBASE           (iBASE),
    .iSTART          (iSTART),
    .iSTOP           (iSTOP),
    .iCONTINUOUS     (iCONTINUOUS),
    .iCROP_X         (iCROP_X),
    .iCROP_Y         (iCROP_Y),
    .iCROP_W         (iCROP_W),
    .iCROP_H         (iCROP_H),
    .oFB_ADDRESS     (oFB_ADDRESS),
    .oFB_WRITE       (oFB_WRITE),
    .oFB_WRITEDATA   (oFB_WRITEDATA),
    .iFB_WAITREQUEST (iFB_WAITREQUEST),
    .oBUSY           (oBUSY),
    .oFRAME_DONE     (oFRAME_DONE),
    .oOVERFLOW       (oOVERFLOW),
    .oFRAME_COUNT    (oFRAME_COUNT)
  );

  always #5 iCLK = ~iCLK;

  int checkCnt = 0;
  int errCnt   = 0;

  // Bus monitor state (written only by the monitor process)
  logic [31:0] wrAddr[$];
  logic [15:0] wrData[$];
  int          doneCnt = 0;
  int          holdErr = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevAddr = '0;
  logic [15:0] prevData = '0;

  // Record completed transfers and done pulses mid-cycle; flag any change
  // of the write request while stalled
  always @(negedge iCLK) begin
    if (iRESETn) begin
      if (prevStall && (!oFB_WRITE || oFB_ADDRESS != prevAddr || oFB_WRITEDATA != prevData))
        holdErr++;
      if (oFB_WRITE && !iFB_WAITREQUEST) begin
        wrAddr.push_back(oFB_ADDRESS);
        wrData.push_back(oFB_WRITEDATA);
      end
      if (oFRAME_DONE) doneCnt++;
      prevStall = oFB_WRITE && iFB_WAITREQUEST;
      prevAddr  = oFB_ADDRESS;
      prevData  = oFB_WRITEDATA;
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ramp pixel i = {8i, 4i+3, 255-8i}; in RGB565 that is {i, i, 31-i}
  function automatic logic [23:0] pixRamp(input int i);
    logic [7:0] r, g, b;
    r = 8'(8 * i);
    g = 8'(4 * i + 3);
    b = 8'(255 - 8 * i);
    return {r, g, b};
  endfunction

  function automatic logic [15:0] expRamp(input int i);
    logic [4:0] r5, b5;
    logic [5:0] g6;
    r5 = 5'(i);
    g6 = 6'(i);
    b5 = 5'(31 - i);
    return {r5, g6, b5};
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic cmdStart(input logic [31:0] base);
    iBASE  = base;
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask

  task automatic cmdStop();
    iSTOP = 1'b1;
    tick();
    iSTOP = 1'b0;
  endtask

  task automatic frameStart();
    iMIPI_START = 1'b1;
    tick();
    iMIPI_START = 1'b0;
  endtask

  task automatic sendPix(input logic [23:0] d);
    iMIPI_DATA      = d;
    iMIPI_DATAVALID = 1'b1;
    tick();
    iMIPI_DATAVALID = 1'b0;
  endtask

  task automatic sendRamp(input int first, input int last);
    for (int i = first; i <= last; i++) sendPix(pixRamp(i));
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (oBUSY && n < 400) begin
      tick();
      n++;
    end
    checkVal(tag, {31'd0, oBUSY}, 32'd0);
  endtask

  int base0, done0;
  logic [15:0] cnt0;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) tick();
    checkVal("rst_write", {31'd0, oFB_WRITE}, 32'd0);
    checkVal("rst_busy",  {31'd0, oBUSY}, 32'd0);
    checkVal("rst_done",  {31'd0, oFRAME_DONE}, 32'd0);
    checkVal("rst_ovf",   {31'd0, oOVERFLOW}, 32'd0);
    checkVal("rst_count", {16'd0, oFRAME_COUNT}, 32'd0);
    checkVal("rst_addr",  oFB_ADDRESS, 32'd0);
    iRESETn = 1'b1;
    tick();

    // ---------------- single-shot solid red frame ----------------
    base0 = wrAddr.size();
    done0 = doneCnt;
    cmdStart(32'h1000);
    checkVal("t1_armed", {31'd0, oBUSY}, 32'd1);
    frameStart();
    for (int i = 0; i < 32; i++) sendPix(24'hFF0000);
    waitIdle("t1_idle");
    checkVal("t1_nwr", wrAddr.size() - base0, 32'd32);
    if (wrAddr.size() - base0 == 32) begin
      for (int i = 0; i < 32; i++) begin
        checkVal($sformatf("t1_addr%0d", i), wrAddr[base0+i], 32'h1000 + 32'(2*i));
        checkVal($sformatf("t1_data%0d", i), {16'd0, wrData[base0+i]}, 32'h0000F800);
      end
    end
    checkVal("t1_done",  doneCnt - done0, 32'd1);
    checkVal("t1_count", {16'd0, oFRAME_COUNT}, 32'd1);
    checkVal("t1_ovf",   {31'd0, oOVERFLOW}, 32'd0);

    // ---------------- overflow under a long stall ----------------
    base0 = wrAddr.size();
    done0 = doneCnt;
    cmdStart(32'h1000);
    iFB_WAITREQUEST = 1'b1;
    frameStart();
    sendRamp(0, 15);
    repeat (23) tick();
    iFB_WAITREQUEST = 1'b0;
    repeat (10) tick();
    sendRamp(16, 31);
    waitIdle("t2_idle");
    checkVal("t2_ovf", {31'd0, oOVERFLOW}, 32'd1);
    // One word parks in the write stage plus four in the FIFO: pixels 0..4
    checkVal("t2_nwr", wrAddr.size() - base0, 32'd21);
    if (wrAddr.size() - base0 == 21) begin
      for (int k = 0; k < 21; k++) begin
        int p;
        p = (k < 5) ? k : k + 11;
        checkVal($sformatf("t2_addr%0d", k), wrAddr[base0+k], 32'h1000 + 32'(2*p));
        checkVal($sformatf("t2_data%0d", k), {16'd0, wrData[base0+k]}, {16'd0, expRamp(p)});
      end
    end
    checkVal("t2_done",  doneCnt - done0, 32'd1);
    checkVal("t2_count", {16'd0, oFRAME_COUNT}, 32'd2);
    checkVal("t2_hold",  holdErr, 32'd0);

`ifdef MIPI_CAPTURE_CROP_EN
    // ---------------- crop window (2,1,4,2) ----------------
    base0 = wrAddr.size();
    iCROP_X = 11'd2; iCROP_Y = 11'd1; iCROP_W = 11'd4; iCROP_H = 11'd2;
    cmdStart(32'h6000);
    iCROP_X = 11'd0; iCROP_Y = 11'd0; iCROP_W = 11'd8; iCROP_H = 11'd4;
    frameStart();
    sendRamp(0, 31);
    waitIdle("tc_idle");
    checkVal("tc_nwr", wrAddr.size() - base0, 32'd8);
    if (wrAddr.size() - base0 == 8) begin
      for (int k = 0; k < 8; k++) begin
        int p;
        p = (1 + k / 4) * 8 + 2 + (k % 4);
        checkVal($sformatf("tc_addr%0d", k), wrAddr[base0+k], 32'h6000 + 32'(2*k));
        checkVal($sformatf("tc_data%0d", k), {16'd0, wrData[base0+k]}, {16'd0, expRamp(p)});
      end
    end
`endif

    // ---------------- continuous x3, stop during frame 4 ----------------
    base0 = wrAddr.size();
    done0 = doneCnt;
    cnt0  = oFRAME_COUNT;
    iCONTINUOUS = 1'b1;
    cmdStart(32'h8000);
    for (int f = 0; f < 3; f++) begin
      frameStart();
      sendRamp(0, 31);
      repeat (8) tick();
      checkVal($sformatf("t3_rearm%0d", f), {31'd0, oBUSY}, 32'd1);
    end
    frameStart();
    sendRamp(0, 9);
    cmdStop();
    waitIdle("t3_idle");
    iCONTINUOUS = 1'b0;
    checkVal("t3_done",  doneCnt - done0, 32'd3);
    checkVal("t3_count", {16'd0, oFRAME_COUNT}, {16'd0, cnt0 + 16'd3});
    checkVal("t3_nwr",   wrAddr.size() - base0, 32'd106);
    if (wrAddr.size() - base0 == 106) begin
      checkVal("t3_f2_first", wrAddr[base0+32], 32'h8000);
      checkVal("t3_last_addr", wrAddr[base0+105], 32'h8012);
      checkVal("t3_last_data", {16'd0, wrData[base0+105]}, {16'd0, expRamp(9)});
    end

    // ---------------- short frame restart, iSTART ignored when armed ----------------
    base0 = wrAddr.size();
    done0 = doneCnt;
    cmdStart(32'h2000);
    cmdStart(32'h3000);
    frameStart();
    sendRamp(0, 9);
    frameStart();
    sendRamp(0, 31);
    waitIdle("t4_idle");
    checkVal("t4_nwr",  wrAddr.size() - base0, 32'd42);
    if (wrAddr.size() - base0 == 42) begin
      checkVal("t4_first",   wrAddr[base0], 32'h2000);
      checkVal("t4_restart", wrAddr[base0+10], 32'h2000);
      checkVal("t4_rs_data", {16'd0, wrData[base0+10]}, {16'd0, expRamp(0)});
      checkVal("t4_last",    wrAddr[base0+41], 32'h203E);
    end
    checkVal("t4_done", doneCnt - done0, 32'd1);

    // ---------------- iSTOP while armed ----------------
    done0 = doneCnt;
    cmdStart(32'h2000);
    cmdStop();
    checkVal("t5_busy", {31'd0, oBUSY}, 32'd0);
    checkVal("t5_done", doneCnt - done0, 32'd0);

    // ---------------- reset mid-write under stall ----------------
    cmdStart(32'h4000);
    iFB_WAITREQUEST = 1'b1;
    frameStart();
    sendRamp(0, 2);
    tick();
    checkVal("t6_pre_write", {31'd0, oFB_WRITE}, 32'd1);
    iRESETn = 1'b0;
    #1;
    checkVal("t6_write", {31'd0, oFB_WRITE}, 32'd0);
    checkVal("t6_addr",  oFB_ADDRESS, 32'd0);
    checkVal("t6_data",  {16'd0, oFB_WRITEDATA}, 32'd0);
    checkVal("t6_busy",  {31'd0, oBUSY}, 32'd0);
    checkVal("t6_count", {16'd0, oFRAME_COUNT}, 32'd0);
    tick();
    iFB_WAITREQUEST = 1'b0;
    iRESETn = 1'b1;
    tick();
    base0 = wrAddr.size();
    done0 = doneCnt;
    cmdStart(32'h5000);
    frameStart();
    sendRamp(0, 31);
    waitIdle("t6_idle");
    checkVal("t6_nwr", wrAddr.size() - base0, 32'd32);
    if (wrAddr.size() - base0 == 32) begin
      checkVal("t6_first_addr", wrAddr[base0], 32'h5000);
      checkVal("t6_first_data", {16'd0, wrData[base0]}, {16'd0, expRamp(0)});
      checkVal("t6_last_addr",  wrAddr[base0+31], 32'h503E);
    end
    checkVal("t6_done",    doneCnt - done0, 32'd1);
    checkVal("t6_count1",  {16'd0, oFRAME_COUNT}, 32'd1);
    checkVal("hold_total", holdErr, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mipi_capture_ctrl.md
# mipi_capture_ctrl

Capture sequencer between the MIPI receiver's RGB888 pixel stream and an Avalon-MM frame-buffer write port. It arms on software command, aligns to the receiver's frame-start strobe, tracks X/Y position, optionally crops, converts to RGB565, buffers through a small FIFO and issues linear-address writes with waitrequest backpressure. It supports single-shot or continuous capture, abort, frame counting and overflow reporting.

## Interface
- pWIDTH, 640, pixels per line (line boundary derived from count)
- pHEIGHT, 480, lines per frame
- pADDR_W, 32, frame-buffer address width (byte address)
- pFIFO_AW, 4, FIFO address width (depth 2^pFIFO_AW)
- iCLK  in  1  clock (same domain as receiver output)
- iRESETn  in  1  asynchronous, active-low reset
- iMIPI_DATA  in  24  {R,G,B} pixel
- iMIPI_START  in  1  frame-start strobe
- iMIPI_DATAVALID  in  1  pixel-valid strobe
- iBASE  in  pADDR_W  frame base byte address, sampled on accepted iSTART
- iSTART / iSTOP  in  1  command pulses
- iCONTINUOUS  in  1  re-arm after each frame
- iCROP_X, iCROP_Y, iCROP_W, iCROP_H  in  11 each  crop window, sampled on accepted iSTART
- oFB_ADDRESS  out  pADDR_W  write byte address
- oFB_WRITE  out  1  write request
- oFB_WRITEDATA  out  16  RGB565
- iFB_WAITREQUEST  in  1  slave stall
- oBUSY  out  1  state != IDLE
- oFRAME_DONE  out  1  one-cycle pulse per completed frame
- oOVERFLOW  out  1  sticky, pixel dropped on full FIFO
- oFRAME_COUNT  out  16  completed frames, wraps 0xFFFF->0

## Operation
- States: IDLE, ARMED, CAPTURE, DRAIN. Reset -> IDLE.
- IDLE: iSTART -> ARMED; latch iBASE and crop, clear oOVERFLOW, write pointer := iBASE. iSTART in any other state ignored.
- ARMED: iMIPI_START -> CAPTURE, X=Y=0. iSTOP -> IDLE.
- CAPTURE: each iMIPI_DATAVALID (not coincident with iMIPI_START; such pixels are ignored everywhere) is one pixel at (X,Y). X increments; at X=pWIDTH-1, X:=0, Y++. The pixel is in-window when cropping is disabled, or when X in [CROP_X, CROP_X+CROP_W) and Y in [CROP_Y, CROP_Y+CROP_H). In-window pixels push {R[7:3],G[7:2],B[7:3]} with the current pointer; the pointer advances by 2 per in-window pixel even if the push is dropped. Frame geometry is preserved.
- The last frame pixel (X=pWIDTH-1, Y=pHEIGHT-1) -> DRAIN. Later pixels are ignored until re-armed.
- iMIPI_START while in CAPTURE (short frame): restart X=Y=0, pointer := latched base, FIFO content kept. There is no oFRAME_DONE and no count for the aborted frame.
- iSTOP in CAPTURE -> DRAIN with an abort flag; nothing further is pushed.
- DRAIN: when the FIFO is empty and no write is pending: if not aborted, pulse oFRAME_DONE and increment oFRAME_COUNT. Then go to ARMED if iCONTINUOUS and not aborted, else IDLE.
- Push when FIFO full: drop the pixel and set oOVERFLOW.

## Timing
- All outputs reset to 0.
- Pixel accepted in cycle N -> FIFO write at edge N+1 -> oFB_WRITE earliest in cycle N+2.
- Avalon: oFB_ADDRESS, oFB_WRITEDATA and oFB_WRITE stay stable while iFB_WAITREQUEST=1. A transfer completes on a cycle with write=1 and waitrequest=0, and the next word may follow in the next cycle (one write/cycle sustained).
- Simultaneous FIFO push and pop is allowed at full and empty; full-flag drop is evaluated before the same-cycle pop (conservative).
- oFRAME_DONE is asserted in the cycle after the last write completes.
- Reset mid-frame: immediate IDLE, FIFO flushed, oFB_WRITE deasserted without completing the transfer.

## Configuration
- MIPI_CAPTURE_CROP_EN defined: crop window logic present; iCROP_* used.
- Undefined: every pixel is in-window; iCROP_* unconnected/ignored. Writes total pWIDTH*pHEIGHT per frame.

## Structure
- Package mipi_capture_pkg: state encoding, RGB888->RGB565 function, default geometry constants.
- Sub-module mipi_capture_fifo: synchronous show-ahead FIFO, width 16+pADDR_W, depth 2^pFIFO_AW, full/empty flags.

## Test plan
- pWIDTH=8, pHEIGHT=4, iBASE=0x1000, no stall, single shot, 32 pixels of 0xFF0000 -> 32 writes of 0xF800 at 0x1000..0x103E, one oFRAME_DONE, count=1, IDLE.
- pFIFO_AW=2, waitrequest high for 40 cycles during a frame -> oOVERFLOW=1, first 4 queued words written correctly. Addresses of dropped pixels are skipped, and the remaining writes land at their geometric addresses.
- CROP_EN, crop (2,1,4,2), ramp data -> exactly 8 writes at base..base+0xE, carrying pixels x2..5 of rows 1..2.
- iCONTINUOUS=1 over 3 frames, then iSTOP mid-frame 4 -> count=3, no 4th oFRAME_DONE, IDLE after drain.
- iMIPI_START after 10 pixels of a frame -> address restarts at base, and one oFRAME_DONE for the subsequent full frame.
- iRESETn low mid-write under stall -> all outputs 0 at once; a new iSTART captures cleanly.
